fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Program-counter and instruction-fetch stage of the single-issue core. It consumes the next-PC value produced by the jump-target mux (`redirect_pc`) and runs the instruction-memory request/response handshake. It presents one fetched instruction at a time to decode under a valid/ready handshake. It also owns start-up and halt sequencing for the core.

## Interface
Parameters:
- `PC_W`, 16, program counter width (matches the jump-target mux output).
- `INSTR_W`, 9, instruction word width.
- `RESET_PC`, 0, PC loaded on reset.
- `PC_STEP`, 1, sequential PC increment.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  leave IDLE and begin fetching.
- `redirect_valid`  in  1  instruction being consumed is a taken jump/branch.
- `redirect_pc`  in  PC_W  target from the jump-target mux.
- `halt`  in  1  instruction being consumed is HALT.
- `imem_req`  out  1  one-cycle fetch request.
- `imem_addr`  out  PC_W  fetch address, always equals current PC.
- `imem_rvalid`  in  1  memory response valid.
- `imem_rdata`  in  INSTR_W  memory response data.
- `instr_valid`  out  1  `instr`/`instr_pc` valid to decode.
- `instr`  out  INSTR_W  held instruction.
- `instr_pc`  out  PC_W  address of held instruction.
- `instr_ready`  in  1  decode consumes instruction this cycle.
- `halted`  out  1  core stopped.

## Operation
- States: IDLE, REQ, WAIT, HOLD, HALT. Encoding is binary. Outputs `imem_req`, `instr_valid`, and `halted` are Moore outputs of state.
- IDLE:
  - pc = RESET_PC.
  - `start` → REQ.
  - `start` is ignored in every other state.
- REQ:
  - `imem_req`=1 for exactly one cycle, `imem_addr`=pc.
  - Unconditional transition → WAIT.
- WAIT:
  - Wait with no timeout.
  - On `imem_rvalid`: latch `instr`←`imem_rdata` and `instr_pc`←pc, then → HOLD.
  - `imem_rvalid` in any state other than WAIT is ignored.
- HOLD:
  - `instr_valid`=1; `instr`/`instr_pc` are stable until consumed.
  - `instr_ready`=0: stay in HOLD.
  - `instr_ready`=1 and `halt`=1: → HALT. Halt has priority over redirect.
  - `instr_ready`=1 and `redirect_valid`=1: pc←`redirect_pc`, → REQ.
  - `instr_ready`=1 otherwise: pc←pc+PC_STEP, → REQ.
  - `redirect_valid` and `halt` are sampled only in HOLD with `instr_ready`=1; ignored elsewhere.
- HALT:
  - `halted`=1; pc frozen; no requests.
  - Only `reset` exits HALT.
- Arithmetic: pc+PC_STEP is truncated to PC_W bits, so 0xFFFF+1 wraps to 0x0000. `redirect_pc` is used unmodified.
- Reset mid-operation (any state, including WAIT with a response outstanding):
  - Returns to IDLE immediately.
  - A late `imem_rvalid` after reset is ignored.

## Timing
- Reset values:
  - State IDLE, pc=RESET_PC, `imem_addr`=RESET_PC.
  - `imem_req`, `instr_valid`, `halted` = 0.
  - `instr`, `instr_pc` = 0.
- `start` high in cycle n → `imem_req` high in cycle n+1.
- `imem_rvalid` in cycle m → `instr_valid` high in cycle m+1.
- Consume in cycle k → next `imem_req` in cycle k+1, with `imem_addr` already updated.
- Best case is 3 cycles per instruction (REQ, WAIT with single-cycle memory, HOLD).
- No combinational path from any input to any output.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds outputs `cycle_count` [31:0] (increments every cycle outside IDLE/HALT) and `retire_count` [31:0] (increments on each HOLD consume).
  - Both counters are cleared by `reset` and wrap at 2^32.
- `FETCH_PERF_EN` undefined: the counter ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum (IDLE, REQ, WAIT, HOLD, HALT).
  - Default constants `PC_W_DEF`, `INSTR_W_DEF`, `RESET_PC_DEF`.
- One sub-module, `fetch_perf_ctr`: the two counters, instantiated only under `FETCH_PERF_EN`.
- FSM and PC register live in `fetch_pc_unit`.

## Test plan
- Reset and start:
  - Reset, then `start` pulse, memory answers the next cycle with 0x055.
  - Expect: `imem_req`@addr 0, `instr`=0x055 with `instr_pc`=0, `instr_valid`.
  - After consume: `imem_req`@addr 1.
- Decode backpressure:
  - Hold `instr_ready`=0 for 5 cycles in HOLD.
  - Expect: `instr`/`instr_pc` stable; no `imem_req`; pc unchanged.
- Redirect:
  - Consume with `redirect_valid`=1, `redirect_pc`=76.
  - Expect: next `imem_req` with `imem_addr`=76; next sequential fetch is 77.
- Halt priority and response filtering:
  - Consume with `halt`=1 and `redirect_valid`=1 → `halted`=1, no further requests.
  - Then `start` and `imem_rvalid` pulses → no change.
- Wrap and reset mid-flight:
  - Redirect to 0xFFFF, then consume → next fetch address 0x0000.
  - Assert `reset` in WAIT, then deliver `imem_rvalid` → state IDLE, `instr_valid`=0.
- Performance counters (`FETCH_PERF_EN`): fetch 3 instructions with single-cycle memory.
  - Expect `retire_count`=3.
  - Expect `cycle_count`=9 at the cycle of the third consume.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_t;

  localparam int unsigned PC_W_DEF     = 16;
  localparam int unsigned INSTR_W_DEF  = 9;
  localparam int unsigned RESET_PC_DEF = 0;
  localparam int unsigned PC_STEP_DEF  = 1;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters: active cycles and retired (consumed) instructions.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        active_c,
  input  logic        retire_c,
  output logic [31:0] cycle_count,
  output logic [31:0] retire_count
);

  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] retire_count_q, retire_count_d;

  always_comb begin
    cycle_count_d  = cycle_count_q;
    retire_count_d = retire_count_q;
    if (active_c) cycle_count_d = cycle_count_q + 32'd1;
    if (retire_c) retire_count_d = retire_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count_q  <= 32'd0;
      retire_count_q <= 32'd0;
    end else begin
      cycle_count_q  <= cycle_count_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign cycle_count  = cycle_count_q;
  assign retire_count = retire_count_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register, imem request/response handshake and start/halt sequencing.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
`ifdef FETCH_PERF_EN
  output logic [31:0]        cycle_count,
  output logic [31:0]        retire_count,
`endif
  output logic               halted
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               imem_req_q, instr_valid_q, halted_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      IDLE: begin
        pc_d = PC_W'(RESET_PC);
        if (start) state_d = REQ;
      end
      REQ:  state_d = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // Halt wins over redirect when both accompany the consumed instruction.
        if (instr_ready) begin
          if (halt) begin
            state_d = HALT;
          end else begin
            pc_d    = redirect_valid ? redirect_pc : pc_q + PC_W'(PC_STEP);
            state_d = REQ;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= PC_W'(RESET_PC);
      instr_q       <= '0;
      instr_pc_q    <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      imem_req_q    <= (state_d == REQ);
      instr_valid_q <= (state_d == HOLD);
      halted_q      <= (state_d == HALT);
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign halted      = halted_q;

`ifdef FETCH_PERF_EN
  // Counting on the next state makes cycle_count include the current cycle.
  logic active_c, retire_c;
  assign active_c = (state_d != IDLE) && (state_d != HALT);
  assign retire_c = (state_q == HOLD) && instr_ready;

  fetch_perf_ctr u_perf (
    .clk          (clk),
    .reset        (reset),
    .active_c     (active_c),
    .retire_c     (retire_c),
    .cycle_count  (cycle_count),
    .retire_count (retire_count)
  );
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; perf counter checks build with FETCH_PERF_EN.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [8:0]  imem_rdata;
  logic        instr_valid;
  logic [8:0]  instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] cycle_count;
  logic [31:0] retire_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
`ifdef FETCH_PERF_EN
    .cycle_count    (cycle_count),
    .retire_count   (retire_count),
`endif
    .halted         (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From REQ: one WAIT cycle with a single-cycle memory response, ending in HOLD.
  task automatic fetch(input logic [8:0] data);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
  endtask

  task automatic consume(input logic rv, input logic [15:0] rpc, input logic h);
    instr_ready    = 1'b1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    tick();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    tick();
    tick();
    check("rst_req",    32'(imem_req), 32'h0);
    check("rst_valid",  32'(instr_valid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_addr",   32'(imem_addr), 32'h0);
    check("rst_instr",  32'(instr), 32'h0);
    check("rst_ipc",    32'(instr_pc), 32'h0);
    reset = 1'b0;
    tick();
    check("idle_noreq", 32'(imem_req), 32'h0);

    // Start and first fetch
    start = 1'b1;
    tick();
    start = 1'b0;
    check("req0",      32'(imem_req), 32'h1);
    check("req0_addr", 32'(imem_addr), 32'h0);
    fetch(9'h055);
    check("hold_valid", 32'(instr_valid), 32'h1);
    check("hold_instr", 32'(instr), 32'h055);
    check("hold_ipc",   32'(instr_pc), 32'h0);
    consume(1'b0, 16'h0, 1'b0);
    check("req1",      32'(imem_req), 32'h1);
    check("req1_addr", 32'(imem_addr), 32'h1);
    check("req1_noval", 32'(instr_valid), 32'h0);

    // Backpressure for 5 cycles in HOLD
    fetch(9'h1A3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(instr_valid), 32'h1);
      check("bp_instr", 32'(instr), 32'h1A3);
      check("bp_ipc",   32'(instr_pc), 32'h1);
      check("bp_noreq", 32'(imem_req), 32'h0);
      check("bp_addr",  32'(imem_addr), 32'h1);
    end

    // Redirect, then sequential follow-on
    consume(1'b1, 16'd76, 1'b0);
    check("redir_req",  32'(imem_req), 32'h1);
    check("redir_addr", 32'(imem_addr), 32'd76);
    fetch(9'h0F0);
    check("redir_ipc",  32'(instr_pc), 32'd76);
    consume(1'b0, 16'd5, 1'b0);
    check("seq_addr",   32'(imem_addr), 32'd77);

    // Halt has priority over redirect; start and rvalid then ignored
    fetch(9'h1FF);
    consume(1'b1, 16'd200, 1'b1);
    check("halt_flag",  32'(halted), 32'h1);
    check("halt_noreq", 32'(imem_req), 32'h0);
    check("halt_noval", 32'(instr_valid), 32'h0);
    start = 1'b1; imem_rvalid = 1'b1; imem_rdata = 9'h033;
    tick();
    tick();
    start = 1'b0; imem_rvalid = 1'b0;
    tick();
    check("halt_stay",  32'(halted), 32'h1);
    check("halt_req2",  32'(imem_req), 32'h0);
    check("halt_addr",  32'(imem_addr), 32'd77);
    check("halt_instr", 32'(instr), 32'h1FF);

    // Wrap at 0xFFFF
    do_reset();
    check("rst2_halted", 32'(halted), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch(9'h001);
    consume(1'b1, 16'hFFFF, 1'b0);
    check("wrap_pre", 32'(imem_addr), 32'hFFFF);
    fetch(9'h002);
    check("wrap_ipc", 32'(instr_pc), 32'hFFFF);
    consume(1'b0, 16'h0, 1'b0);
    check("wrap_req",  32'(imem_req), 32'h1);
    check("wrap_addr", 32'(imem_addr), 32'h0);
    consume(1'b1, 16'h1234, 1'b0);
    check("wrap_norediR", 32'(imem_addr), 32'h0);

    // Reset in WAIT, then a late response
    tick();
    reset = 1'b1;
    #2;
    check("mid_rst_req",  32'(imem_req), 32'h0);
    check("mid_rst_addr", 32'(imem_addr), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 9'h0AA;
    tick();
    imem_rvalid = 1'b0;
    tick();
    check("late_noval", 32'(instr_valid), 32'h0);
    check("late_noreq", 32'(imem_req), 32'h0);
    check("late_instr", 32'(instr), 32'h0);

`ifdef FETCH_PERF_EN
    do_reset();
    check("perf_rst_cyc", cycle_count, 32'd0);
    check("perf_rst_ret", retire_count, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch(9'h011);
    check("perf_cyc3", cycle_count, 32'd3);
    consume(1'b0, 16'h0, 1'b0);
    fetch(9'h012);
    consume(1'b0, 16'h0, 1'b0);
    fetch(9'h013);
    check("perf_cyc9", cycle_count, 32'd9);
    check("perf_ret2", retire_count, 32'd2);
    consume(1'b0, 16'h0, 1'b0);
    check("perf_ret3", retire_count, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
